// File: rtl/life_pkg.sv
// Shared types and helpers for the life manager.
//   life_state_t : player life-cycle state, also driven on life_manager.state
//   sat_inc      : increment that saturates at a ceiling
package life_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        GRACE     = 2'd2,
        GAME_OVER = 2'd3
    } life_state_t;

    // Returns value+1, but never more than max_v.
    function automatic int unsigned sat_inc(input int unsigned value, input int unsigned max_v);
        return (value >= max_v) ? max_v : value + 1;
    endfunction

endpackage

// File: rtl/life_manager_rise_detect.sv
// Rising-edge detector. The previous-sample register has a configurable
// reset value so a level already high when reset is released can be
// treated as "seen" rather than as a fresh edge.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   i_d        : level input
//   o_rise     : high for the cycle where i_d is high and was low last cycle
module rise_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/life_manager.sv
// Life manager: spare-life counter with bonus awards, death / respawn /
// invulnerability sequencing over frame ticks, and game-over detection.
// Ports:
//   clock, Reset_n : clock, asynchronous active-low reset
//   new_game       : synchronous restart pulse (valid in every state)
//   fail           : collision level, only its rising edge counts
//   bonus          : award-one-life pulse
//   frame_tick     : once-per-frame pulse timing DYING and GRACE
//   lives          : remaining spare lives
//   state          : current life_state_t
//   invulnerable   : high in DYING and GRACE
//   life_lost      : one-cycle pulse when a fail is accepted
//   respawn        : one-cycle pulse when DYING ends
//   game_over      : high in GAME_OVER
// All outputs are registered.
module life_manager
    import life_pkg::*;
#(
    parameter int START_LIVES = 2,
    parameter int MAX_LIVES   = 5,
    parameter int DEATH_TICKS = 60,
    parameter int GRACE_TICKS = 120,
    localparam int LW = $clog2(MAX_LIVES + 1)
) (
    input  logic          clock,
    input  logic          Reset_n,
    input  logic          new_game,
    input  logic          fail,
    input  logic          bonus,
    input  logic          frame_tick,
    output logic [LW-1:0] lives,
    output life_state_t   state,
    output logic          invulnerable,
    output logic          life_lost,
    output logic          respawn,
    output logic          game_over
);

    localparam int TMAX       = (DEATH_TICKS > GRACE_TICKS) ? DEATH_TICKS : GRACE_TICKS;
    localparam int TW         = $clog2(TMAX + 1);
    localparam int DEATH_LAST = DEATH_TICKS - 1;
    // GRACE is unreachable when GRACE_TICKS is 0; keep the constant in range anyway.
    localparam int GRACE_LAST = (GRACE_TICKS > 0) ? GRACE_TICKS - 1 : 0;

    logic [LW-1:0] r_lives;
    life_state_t   r_state;
    logic [TW-1:0] r_tick;
    logic          r_life_lost;
    logic          r_respawn;
    logic          r_invuln;
    logic          r_game_over;

    logic          w_fail_evt;
    logic          w_bonus_ok;
    logic [LW-1:0] w_lives_b;
    logic [LW-1:0] w_lives_next;
    life_state_t   w_state_next;
    logic [TW-1:0] w_tick_next;
    logic          w_life_lost_next;
    logic          w_respawn_next;

    // Resets high so a fail level held through reset release is not an edge.
    // Its register samples fail every cycle, which also gives the
    // new_game behaviour of reloading with the current fail level.
    rise_detect #(
        .RST_VAL (1'b1)
    ) u_fail_edge (
        .clk    (clock),
        .rst_n  (Reset_n),
        .i_d    (fail),
        .o_rise (w_fail_evt)
    );

    always_comb begin
        w_bonus_ok       = bonus && (r_state != GAME_OVER);
        w_lives_b        = w_bonus_ok ? LW'(sat_inc(32'(r_lives), MAX_LIVES)) : r_lives;
        w_lives_next     = r_lives;
        w_state_next     = r_state;
        w_tick_next      = r_tick;
        w_life_lost_next = 1'b0;
        w_respawn_next   = 1'b0;

        if (new_game) begin
            w_lives_next = LW'(START_LIVES);
            w_state_next = ALIVE;
            w_tick_next  = '0;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (w_fail_evt) begin
                        w_life_lost_next = 1'b1;
                        // The bonus of the same cycle is credited before the
                        // loss, so bonus+fail at 0 lives still survives.
                        if (w_lives_b != '0) begin
                            w_lives_next = w_lives_b - 1'b1;
                            w_state_next = DYING;
                            w_tick_next  = '0;
                        end else begin
                            w_lives_next = '0;
                            w_state_next = GAME_OVER;
                        end
                    end else begin
                        w_lives_next = w_lives_b;
                    end
                end
                DYING: begin
                    w_lives_next = w_lives_b;
                    if (frame_tick) begin
                        if (r_tick == TW'(DEATH_LAST)) begin
                            w_respawn_next = 1'b1;
                            w_tick_next    = '0;
                            w_state_next   = (GRACE_TICKS == 0) ? ALIVE : GRACE;
                        end else begin
                            w_tick_next = r_tick + 1'b1;
                        end
                    end
                end
                GRACE: begin
                    w_lives_next = w_lives_b;
                    if (frame_tick) begin
                        if (r_tick == TW'(GRACE_LAST)) begin
                            w_tick_next  = '0;
                            w_state_next = ALIVE;
                        end else begin
                            w_tick_next = r_tick + 1'b1;
                        end
                    end
                end
                default: begin
                    // GAME_OVER holds until new_game or reset.
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lives     <= LW'(START_LIVES);
            r_state     <= ALIVE;
            r_tick      <= '0;
            r_life_lost <= 1'b0;
            r_respawn   <= 1'b0;
            r_invuln    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_lives     <= w_lives_next;
            r_state     <= w_state_next;
            r_tick      <= w_tick_next;
            r_life_lost <= w_life_lost_next;
            r_respawn   <= w_respawn_next;
            r_invuln    <= (w_state_next == DYING) || (w_state_next == GRACE);
            r_game_over <= (w_state_next == GAME_OVER);
        end
    end

    assign lives        = r_lives;
    assign state        = r_state;
    assign invulnerable = r_invuln;
    assign life_lost    = r_life_lost;
    assign respawn      = r_respawn;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_life_manager.sv
// Scoreboard bench for life_manager with START_LIVES=2, MAX_LIVES=5,
// DEATH_TICKS=3, GRACE_TICKS=2. Each stimulus cycle pushes the expected
// post-edge outputs; a monitor pops and compares on the falling edge.
module tb_life_manager;
    import life_pkg::*;

    localparam int LW = 3;

    logic          clock;
    logic          Reset_n;
    logic          new_game;
    logic          fail;
    logic          bonus;
    logic          frame_tick;
    logic [LW-1:0] lives;
    life_state_t   state;
    logic          invulnerable;
    logic          life_lost;
    logic          respawn;
    logic          game_over;

    typedef struct {
        string       name;
        int          at;
        int          lives;
        life_state_t state;
        logic        ll;
        logic        rs;
    } rec_t;

    rec_t sb[$];
    int   ncount = 0;
    int   tests  = 0;
    int   fails  = 0;

    life_manager #(
        .START_LIVES (2),
        .MAX_LIVES   (5),
        .DEATH_TICKS (3),
        .GRACE_TICKS (2)
    ) dut (
        .clock        (clock),
        .Reset_n      (Reset_n),
        .new_game     (new_game),
        .fail         (fail),
        .bonus        (bonus),
        .frame_tick   (frame_tick),
        .lives        (lives),
        .state        (state),
        .invulnerable (invulnerable),
        .life_lost    (life_lost),
        .respawn      (respawn),
        .game_over    (game_over)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_rec(input rec_t r);
        logic exp_inv;
        logic exp_go;
        exp_inv = (r.state == DYING) || (r.state == GRACE);
        exp_go  = (r.state == GAME_OVER);
        tests++;
        if (int'(lives) !== r.lives || state !== r.state || invulnerable !== exp_inv ||
            game_over !== exp_go || life_lost !== r.ll || respawn !== r.rs) begin
            fails++;
            $display("FAIL %s: got lives=%0d state=%0d inv=%b go=%b ll=%b rs=%b, want lives=%0d state=%0d inv=%b go=%b ll=%b rs=%b",
                     r.name, lives, state, invulnerable, game_over, life_lost, respawn,
                     r.lives, r.state, exp_inv, exp_go, r.ll, r.rs);
        end else begin
            $display("[TB] ok %s: lives=%0d state=%0d ll=%b rs=%b", r.name, lives, state, life_lost, respawn);
        end
    endtask

    // Monitor: compares every expectation due at this falling edge.
    initial begin
        forever begin
            @(negedge clock);
            ncount = ncount + 1;
            while (sb.size() > 0 && sb[0].at <= ncount) begin
                check_rec(sb.pop_front());
            end
        end
    end

    task automatic step(input string nm, input logic ng, input logic f, input logic b,
                        input logic ft, input int el, input life_state_t es,
                        input logic ell, input logic ers);
        rec_t r;
        @(negedge clock);
        #1;
        new_game   = ng;
        fail       = f;
        bonus      = b;
        frame_tick = ft;
        r.name  = nm;
        r.at    = ncount + 1;
        r.lives = el;
        r.state = es;
        r.ll    = ell;
        r.rs    = ers;
        sb.push_back(r);
    endtask

    task automatic check_now(input string nm, input int el, input life_state_t es);
        rec_t r;
        r.name  = nm;
        r.at    = ncount;
        r.lives = el;
        r.state = es;
        r.ll    = 1'b0;
        r.rs    = 1'b0;
        check_rec(r);
    endtask

    initial begin
        Reset_n    = 1'b1;
        new_game   = 1'b0;
        fail       = 1'b1;
        bonus      = 1'b0;
        frame_tick = 1'b0;
        #1 Reset_n = 1'b0;
        #2 check_now("reset_values", 2, ALIVE);
        repeat (2) @(negedge clock);
        #1 Reset_n = 1'b1;

        // fail held high through reset release is not an event
        step("hold_fail_a",     0, 1, 0, 0, 2, ALIVE, 0, 0);
        step("hold_fail_b",     0, 1, 0, 0, 2, ALIVE, 0, 0);
        step("fail_low",        0, 0, 0, 0, 2, ALIVE, 0, 0);
        step("first_fail",      0, 1, 0, 0, 1, DYING, 1, 0);
        step("ll_one_cycle",    0, 1, 0, 0, 1, DYING, 0, 0);
        step("dying_tick1",     0, 1, 0, 1, 1, DYING, 0, 0);
        step("dying_idle",      0, 1, 0, 0, 1, DYING, 0, 0);
        step("dying_tick2",     0, 1, 0, 1, 1, DYING, 0, 0);
        step("respawn_1",       0, 1, 0, 1, 1, GRACE, 0, 1);
        step("grace_idle",      0, 1, 0, 0, 1, GRACE, 0, 0);
        step("grace_fail_low",  0, 0, 0, 0, 1, GRACE, 0, 0);
        step("grace_fail_edge", 0, 1, 0, 0, 1, GRACE, 0, 0);
        step("grace_tick1",     0, 1, 0, 1, 1, GRACE, 0, 0);
        step("grace_done",      0, 1, 0, 1, 1, ALIVE, 0, 0);
        step("held_not_recount",0, 1, 0, 0, 1, ALIVE, 0, 0);
        step("fail_low_2",      0, 0, 0, 0, 1, ALIVE, 0, 0);
        step("second_fail",     0, 1, 0, 0, 0, DYING, 1, 0);
        step("d2_tick1",        0, 0, 0, 1, 0, DYING, 0, 0);
        step("d2_tick2",        0, 0, 0, 1, 0, DYING, 0, 0);
        step("respawn_2",       0, 0, 0, 1, 0, GRACE, 0, 1);
        step("g2_tick1",        0, 0, 0, 1, 0, GRACE, 0, 0);
        step("g2_done",         0, 0, 0, 1, 0, ALIVE, 0, 0);
        // last life gone
        step("game_over",       0, 1, 0, 0, 0, GAME_OVER, 1, 0);
        step("go_bonus",        0, 0, 1, 0, 0, GAME_OVER, 0, 0);
        step("go_fail",         0, 1, 0, 0, 0, GAME_OVER, 0, 0);
        step("new_game",        1, 1, 1, 0, 2, ALIVE, 0, 0);
        step("ng_fail_held",    0, 1, 0, 0, 2, ALIVE, 0, 0);
        // saturation
        step("bonus_3",         0, 0, 1, 0, 3, ALIVE, 0, 0);
        step("bonus_4",         0, 0, 1, 0, 4, ALIVE, 0, 0);
        step("bonus_5",         0, 0, 1, 0, 5, ALIVE, 0, 0);
        step("bonus_sat_a",     0, 0, 1, 0, 5, ALIVE, 0, 0);
        step("bonus_sat_b",     0, 0, 1, 0, 5, ALIVE, 0, 0);
        step("bonus_fail_max",  0, 1, 1, 0, 4, DYING, 1, 0);
        step("dying_bonus",     0, 0, 1, 1, 5, DYING, 0, 0);
        step("d3_tick2",        0, 0, 0, 1, 5, DYING, 0, 0);
        step("respawn_3",       0, 0, 0, 1, 5, GRACE, 0, 1);
        step("new_game_grace",  1, 0, 0, 0, 2, ALIVE, 0, 0);
        // walk down to zero lives
        step("w_fail_a",        0, 1, 0, 0, 1, DYING, 1, 0);
        step("w_t1",            0, 0, 0, 1, 1, DYING, 0, 0);
        step("w_t2",            0, 0, 0, 1, 1, DYING, 0, 0);
        step("w_rs_a",          0, 0, 0, 1, 1, GRACE, 0, 1);
        step("w_g1",            0, 0, 0, 1, 1, GRACE, 0, 0);
        step("w_g2",            0, 0, 0, 1, 1, ALIVE, 0, 0);
        step("w_fail_b",        0, 1, 0, 0, 0, DYING, 1, 0);
        step("w_t3",            0, 0, 0, 1, 0, DYING, 0, 0);
        step("w_t4",            0, 0, 0, 1, 0, DYING, 0, 0);
        step("w_rs_b",          0, 0, 0, 1, 0, GRACE, 0, 1);
        step("w_g3",            0, 0, 0, 1, 0, GRACE, 0, 0);
        step("w_g4",            0, 0, 0, 1, 0, ALIVE, 0, 0);
        step("zero_idle",       0, 0, 0, 0, 0, ALIVE, 0, 0);
        step("bonus_fail_zero", 0, 1, 1, 0, 0, DYING, 1, 0);
        step("z_tick1",         0, 1, 0, 1, 0, DYING, 0, 0);

        // asynchronous reset between clock edges, mid-DYING
        @(negedge clock);
        #1;
        new_game   = 1'b0;
        fail       = 1'b1;
        bonus      = 1'b0;
        frame_tick = 1'b0;
        #2 Reset_n = 1'b0;
        #1 check_now("async_reset", 2, ALIVE);
        @(negedge clock);
        #1 Reset_n = 1'b1;
        step("after_reset",     0, 1, 0, 0, 2, ALIVE, 0, 0);
        step("after_reset_b",   0, 0, 0, 0, 2, ALIVE, 0, 0);

        repeat (3) @(negedge clock);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
